// File: rtl/spi_slave_if.sv
// SPI responder pin and user-side bundle; slave modport faces the spi_slave core.
// frameErr exists only when SPI_SLAVE_FRAME_ERR_EN is defined.
interface spi_slave_if #(
  parameter int unsigned BITS = 16
);
  logic            sck;
  logic            cs;
  logic            sdi;
  logic            sdo;
  logic            sdoEn;
  logic [BITS-1:0] txData;
  logic            txReq;
  logic [BITS-1:0] rxData;
  logic            rxValid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic            frameErr;

  modport master (
    output sck, cs, sdi, txData,
    input  sdo, sdoEn, txReq, rxData, rxValid, frameErr
  );

  modport slave (
    input  sck, cs, sdi, txData,
    output sdo, sdoEn, txReq, rxData, rxValid, frameErr
  );
`else
  modport master (
    output sck, cs, sdi, txData,
    input  sdo, sdoEn, txReq, rxData, rxValid
  );

  modport slave (
    input  sck, cs, sdi, txData,
    output sdo, sdoEn, txReq, rxData, rxValid
  );
`endif
endinterface

// File: rtl/spi_slave.sv
// Oversampling SPI responder: shifts one BITS-wide word per frame in/out, MSB first.
// Define SPI_SLAVE_FRAME_ERR_EN to add the frameErr pulse for aborted partial words.
module spi_slave #(
  parameter int unsigned BITS   = 16,
  parameter logic        SCKINT = 1'b1,
  parameter logic        SPEDGE = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  spi_slave_if.slave  spi_io
);

  localparam int unsigned CntW = $clog2(BITS + 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sck_sync_q, cs_sync_q;  // [0],[1] synchronizer, [2] edge-detect
  logic [1:0]      sdi_sync_q;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [BITS-1:0] rx_shift_q, rx_shift_d;
  logic [BITS-1:0] tx_shift_q, tx_shift_d;
  logic [BITS-1:0] rx_data_q, rx_data_d;
  logic            skip_q, skip_d;
  logic            sdo_en_q, sdo_en_d;
  logic            sdo_q, sdo_d;
  logic            rx_valid_q, rx_valid_d;
  logic            tx_req_q, tx_req_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic            frame_err_q, frame_err_d;
`endif

  logic sck_edge, lead_ev, trail_ev, sample_ev, shift_ev, cs_fall, cs_rise, sdi_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= {3{SCKINT}};
      cs_sync_q  <= 3'b111;
      sdi_sync_q <= 2'b00;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], spi_io.sck};
      cs_sync_q  <= {cs_sync_q[1:0], spi_io.cs};
      sdi_sync_q <= {sdi_sync_q[0], spi_io.sdi};
    end
  end

  // sdi_s has the same depth as the synchronized sck, so it lines up with the sck event.
  always_comb begin
    sdi_s     = sdi_sync_q[1];
    sck_edge  = sck_sync_q[1] ^ sck_sync_q[2];
    lead_ev   = sck_edge & (sck_sync_q[1] != SCKINT);
    trail_ev  = sck_edge & (sck_sync_q[1] == SCKINT);
    sample_ev = SPEDGE ? trail_ev : lead_ev;
    shift_ev  = SPEDGE ? lead_ev : trail_ev;
    cs_fall   = cs_sync_q[2] & ~cs_sync_q[1];
    cs_rise   = ~cs_sync_q[2] & cs_sync_q[1];
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    skip_d     = skip_q;
    sdo_en_d   = sdo_en_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          tx_shift_d = spi_io.txData;
          tx_req_d   = 1'b1;
          bit_cnt_d  = '0;
          skip_d     = SPEDGE;
          sdo_en_d   = 1'b1;
          state_d    = StActive;
        end
      end
      StActive: begin
        // cs release takes priority over any sck edge seen in the same cycle.
        if (cs_rise) begin
          state_d   = StIdle;
          sdo_en_d  = 1'b0;
          bit_cnt_d = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
          frame_err_d = (bit_cnt_q != '0);
`endif
        end else if (sample_ev) begin
          rx_shift_d = {rx_shift_q[BITS-2:0], sdi_s};
          if (bit_cnt_q == CntW'(BITS - 1)) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            tx_shift_d = spi_io.txData;
            tx_req_d   = 1'b1;
            skip_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_ev) begin
          // The freshly loaded MSB is already on sdo, so the first shift edge is a no-op.
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[BITS-2:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase
    sdo_d = sdo_en_d & tx_shift_d[BITS-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      skip_q     <= 1'b0;
      sdo_en_q   <= 1'b0;
      sdo_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      skip_q     <= skip_d;
      sdo_en_q   <= sdo_en_d;
      sdo_q      <= sdo_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign spi_io.sdo     = sdo_q;
  assign spi_io.sdoEn   = sdo_en_q;
  assign spi_io.txReq   = tx_req_q;
  assign spi_io.rxData  = rx_data_q;
  assign spi_io.rxValid = rx_valid_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign spi_io.frameErr = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: dut_a runs CPOL=1/sample-leading, dut_b CPOL=0/sample-trailing.
// A small SPI master model drives pins on clk negedges at sck = clk/8.
module tb_spi_slave;

  localparam logic [1:0] CPOL = 2'b01;  // index 0 = dut_a, 1 = dut_b
  localparam logic [1:0] CPHA = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sck_m = CPOL;
  logic [1:0]  cs_m = 2'b11;
  logic [1:0]  sdi_m = 2'b00;
  logic [15:0] txd [2];
  logic [1:0]  sdo_w;

  int n_checks = 0;
  int n_pass = 0;
  int rxv_cnt0 = 0, rxv_cnt1 = 0, txr_cnt0 = 0, en_cnt0 = 0;
  logic [15:0] rx_hist0 = '0, rx_hist1 = '0;

  always #5 clk = ~clk;

  spi_slave_if #(.BITS(16)) if_a ();
  spi_slave_if #(.BITS(16)) if_b ();

  assign if_a.sck    = sck_m[0];
  assign if_a.cs     = cs_m[0];
  assign if_a.sdi    = sdi_m[0];
  assign if_a.txData = txd[0];
  assign if_b.sck    = sck_m[1];
  assign if_b.cs     = cs_m[1];
  assign if_b.sdi    = sdi_m[1];
  assign if_b.txData = txd[1];
  assign sdo_w       = {if_b.sdo, if_a.sdo};

  spi_slave #(.BITS(16), .SCKINT(1'b1), .SPEDGE(1'b0)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .spi_io (if_a)
  );

  spi_slave #(.BITS(16), .SCKINT(1'b0), .SPEDGE(1'b1)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .spi_io (if_b)
  );

  always @(posedge clk) begin
    if (if_a.rxValid) begin
      rxv_cnt0++;
      rx_hist1 <= rx_hist0;
      rx_hist0 <= if_a.rxData;
    end
    if (if_a.txReq) txr_cnt0++;
    if (if_a.sdoEn) en_cnt0++;
  end

  always @(posedge clk) begin
    if (if_b.rxValid) rxv_cnt1++;
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  int ferr_cnt0 = 0;
  always @(posedge clk) begin
    if (if_a.frameErr) ferr_cnt0++;
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low(input int d);
    cs_m[d] = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high(input int d);
    wait_clk(4);
    cs_m[d] = 1'b1;
    wait_clk(8);
  endtask

  // Shifts n bits of mo (mo[n-1] first) and returns what was read from sdo.
  task automatic shift_bits(input int d, input int n, input logic [31:0] mo,
                            output logic [31:0] mi);
    mi = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!CPHA[d]) begin
        sdi_m[d] = mo[i];
        wait_clk(4);
        sck_m[d] = ~CPOL[d];
        mi = {mi[30:0], sdo_w[d]};
        wait_clk(4);
        sck_m[d] = CPOL[d];
      end else begin
        wait_clk(4);
        sck_m[d] = ~CPOL[d];
        sdi_m[d] = mo[i];
        wait_clk(4);
        mi = {mi[30:0], sdo_w[d]};
        sck_m[d] = CPOL[d];
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] mi;
    int rxv_b, rxv_b1, txr_b, en_b;
    txd[0] = 16'h0000;
    txd[1] = 16'h0000;
    wait_clk(4);
    check("rst_a_outputs", {if_a.sdo, if_a.sdoEn, if_a.txReq, if_a.rxValid, if_a.rxData}, 0);
    check("rst_b_outputs", {if_b.sdo, if_b.sdoEn, if_b.txReq, if_b.rxValid, if_b.rxData}, 0);
    rst_n = 1'b1;
    wait_clk(6);

    // Single word, mode CPOL=1 / sample leading.
    txd[0] = 16'h3C5A;
    rxv_b = rxv_cnt0;
    txr_b = txr_cnt0;
    cs_low(0);
    check("single_sdoen_on", {31'd0, if_a.sdoEn}, 1);
    shift_bits(0, 16, 32'h0000_A5C3, mi);
    cs_high(0);
    check("single_rxdata", {16'd0, if_a.rxData}, 32'hA5C3);
    check("single_rxvalid_cnt", rxv_cnt0 - rxv_b, 1);
    check("single_miso", mi, 32'h3C5A);
    check("single_txreq_cnt", txr_cnt0 - txr_b, 2);
    check("single_sdoen_off", {31'd0, if_a.sdoEn}, 0);

    // Two back-to-back words with txData updated after the first txReq.
    txd[0] = 16'h8001;
    rxv_b = rxv_cnt0;
    txr_b = txr_cnt0;
    cs_low(0);
    check("burst_txreq_at_cs", txr_cnt0 - txr_b, 1);
    txd[0] = 16'h00F0;
    shift_bits(0, 32, 32'h1234_FFFF, mi);
    cs_high(0);
    check("burst_rxvalid_cnt", rxv_cnt0 - rxv_b, 2);
    check("burst_word0", {16'd0, rx_hist1}, 32'h1234);
    check("burst_word1", {16'd0, rx_hist0}, 32'hFFFF);
    check("burst_miso", mi, 32'h8001_00F0);

    // Mode CPOL=0 / sample trailing: first leading edge must not shift.
    txd[1] = 16'hFFFE;
    rxv_b1 = rxv_cnt1;
    cs_low(1);
    shift_bits(1, 16, 32'h0000_0001, mi);
    cs_high(1);
    check("mode1_rxdata", {16'd0, if_b.rxData}, 32'h0001);
    check("mode1_rxvalid_cnt", rxv_cnt1 - rxv_b1, 1);
    check("mode1_miso", mi, 32'hFFFE);

    // Abort after 7 bits, then a clean frame.
    txd[0] = 16'h0F0F;
    rxv_b = rxv_cnt0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    begin
      int fe_b;
      fe_b = ferr_cnt0;
`endif
    cs_low(0);
    shift_bits(0, 7, 32'h0000_0055, mi);
    cs_high(0);
    check("abort_rxvalid_cnt", rxv_cnt0 - rxv_b, 0);
    check("abort_rxdata_kept", {16'd0, if_a.rxData}, 32'hFFFF);
    check("abort_sdoen_off", {31'd0, if_a.sdoEn}, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      check("abort_frameerr_cnt", ferr_cnt0 - fe_b, 1);
    end
`endif
    cs_low(0);
    shift_bits(0, 16, 32'h0000_5555, mi);
    cs_high(0);
    check("after_abort_rxdata", {16'd0, if_a.rxData}, 32'h5555);
    check("after_abort_miso", mi, 32'h0F0F);

    // Asynchronous reset in the middle of a frame (after bit 9).
    txd[0] = 16'h1357;
    cs_low(0);
    shift_bits(0, 9, 32'h0000_01AA, mi);
    check("midrst_sdoen_before", {31'd0, if_a.sdoEn}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs",
          {if_a.sdo, if_a.sdoEn, if_a.txReq, if_a.rxValid, if_a.rxData}, 0);
    wait_clk(3);
    cs_m[0] = 1'b1;
    sck_m[0] = CPOL[0];
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    rxv_b = rxv_cnt0;
    cs_low(0);
    shift_bits(0, 16, 32'h0000_C0DE, mi);
    cs_high(0);
    check("post_rst_rxdata", {16'd0, if_a.rxData}, 32'hC0DE);
    check("post_rst_rxvalid_cnt", rxv_cnt0 - rxv_b, 1);
    check("post_rst_miso", mi, 32'h1357);

    // sck activity while deselected must be ignored.
    rxv_b = rxv_cnt0;
    txr_b = txr_cnt0;
    en_b  = en_cnt0;
    shift_bits(0, 16, 32'h0000_9E37, mi);
    wait_clk(8);
    check("idle_sck_rxvalid", rxv_cnt0 - rxv_b, 0);
    check("idle_sck_txreq", txr_cnt0 - txr_b, 0);
    check("idle_sck_sdoen", en_cnt0 - en_b, 0);
    check("idle_sck_rxdata", {16'd0, if_a.rxData}, 32'hC0DE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) that pairs with the team's SPI master over the same sck/cs/sdo/sdi pins.
- Oversamples the master's sck, cs and sdi with the local system clock.
- Shifts in one BITS-wide word per frame and shifts out a preloaded word MSB-first; supports back-to-back words while cs stays low.
- Sits at the chip boundary of a peripheral/test FPGA, feeding a register file or FIFO.

Parameters:
- BITS, 16, word length in bits (>=2)
- SCKINT, 1'b1, sck idle level (CPOL); the leading edge is the transition away from SCKINT
- SPEDGE, 1'b0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge

Ports:
- clk  in  1  system clock; must be >= 8x sck frequency
- rst_n  in  1  reset
- sck  in  1  SPI clock from master (asynchronous)
- cs  in  1  chip select from master, active-low (asynchronous)
- sdi  in  1  master-out data (asynchronous)
- sdo  out  1  slave-out data
- sdoEn  out  1  sdo output enable (1 while selected)
- txData  in  BITS  word to transmit; captured on every shifter load
- txReq  out  1  one-cycle pulse: txData was just captured, present the next word
- rxData  out  BITS  last complete received word
- rxValid  out  1  one-cycle pulse: rxData updated

Interface fixed: one clock clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, async): sdo=0, sdoEn=0, txReq=0, rxData=0, rxValid=0; bitCnt=0; shifters=0; synchronizers load idle values (sck=SCKINT, cs=1, sdi=0); state IDLE.
- Input path: sck, cs and sdi each pass through a 2-FF synchronizer plus one edge-detect register.
  - Pin edge to internal event latency: 3 clk.
  - sdi is sampled from the synchronized copy aligned with the sck event.
- States:
  - IDLE: cs_s=1. On a cs_s falling edge: load the tx shifter from txData, pulse txReq, bitCnt=0, set skip=SPEDGE, sdoEn=1, go to ACTIVE.
  - ACTIVE: on a cs_s rising edge go to IDLE, sdoEn=0, bitCnt=0. There is no rxValid for a partial word.
- Sample edge (leading if SPEDGE=0, trailing if SPEDGE=1):
  - rxShift <= {rxShift[BITS-2:0], sdi_s}; bitCnt++.
  - On the BITS-th sample: rxData <= new word and rxValid=1 on the next cycle; bitCnt=0; reload the tx shifter from txData; pulse txReq; skip=1.
- Shift edge (the other edge): if skip=1, clear skip and do not shift; else txShift <= txShift<<1.
- sdo = txShift[BITS-1] registered; sdo=0 while sdoEn=0.
- Sample and shift edges never occur in the same clk cycle.
- If a cs_s rising edge and an sck edge are detected in the same cycle, the cs edge wins and the sck edge is ignored.
- sck edges while in IDLE are ignored.
- txData must be stable at the load cycle. The user has BITS bit-times after txReq to update it.
- bitCnt width is $clog2(BITS+1); it wraps only through the word-boundary reload.

Optional Feature:
- Macro SPI_SLAVE_FRAME_ERR_EN.
- Defined: adds output frameErr (1 bit, reset 0). It pulses 1 cycle when cs_s rises with 0<bitCnt<BITS, i.e. a partial word is aborted. The partial word is discarded.
- Undefined: no port is added; a partial word is discarded silently.

Test Plan:
- SCKINT=1, SPEDGE=0, BITS=16; master sends 0xA5C3 with txData=0x3C5A, clk=8x sck -> rxData=0xA5C3 with exactly one rxValid pulse; master receives 0x3C5A; txReq pulses once at cs fall and once at the word boundary.
- Burst: cs held low for 2 words; master sends 0x1234, 0xFFFF; txData 0x8001 then 0x00F0, changed after the first txReq -> two rxValid pulses (0x1234, 0xFFFF); master receives 0x8001, 0x00F0.
- SCKINT=0, SPEDGE=1; master sends 0x0001; txData=0xFFFE -> rxData=0x0001; master receives 0xFFFE; the first leading edge does not shift.
- Abort: cs rises after 7 bits -> no rxValid; rxData keeps its previous value; sdoEn=0; frameErr pulses once if SPI_SLAVE_FRAME_ERR_EN is defined. The next full frame of 0x5555 is received correctly.
- rst_n asserted mid-frame (bit 9) -> all outputs 0 immediately (async). After release, a fresh frame of 0xC0DE is received correctly.
- sck toggling while cs=1 -> no rxValid, no txReq, sdoEn stays 0.
